lvda_data_receiver: RTL and testbench
=====================================

Name: lvda_data_receiver

Overview:
- Downstream consumer of the LVDA serial data output DATAV, on the computer side of the PIO interface.
- On each PIO input transfer it shifts the serial word in, one bit per bit-time strobe, and assembles a 26-bit word.
- It computes odd parity and presents the word through a one-entry hold register with a valid/ready handshake to the accumulator-load logic.
- It detects aborted transfers, stalled transfers and overruns.

Parameters:
- WORD_BITS, 26, number of serial bits per transfer; the first bit received lands in the MSB.
- TIMEOUT, 64, number of SIM_CLK cycles allowed between consecutive BIT_STB pulses inside a transfer before it is aborted.
- CW, 7, counter width for the bit and timeout counters; must satisfy 2^CW > max(WORD_BITS, TIMEOUT).

Ports:
- SIM_CLK  in  1  single system clock; all state is updated on its rising edge.
- SIM_RST  in  1  asynchronous, active-high reset.
- DATAV  in  1  serial data from the LVDA, sampled only in cycles where BIT_STB=1.
- PIOV  in  1  PIO input-transfer enable; its rising edge starts a transfer, and it stays high for the whole transfer.
- BIT_STB  in  1  one-cycle pulse marking each bit time.
- ACC_RDY  in  1  consumer ready; a word is accepted when WORD_VLD & ACC_RDY.
- CLR_OVRN  in  1  synchronous clear of the OVRN flag.
- WORD  out  WORD_BITS  assembled word, held stable while WORD_VLD=1.
- WORD_VLD  out  1  hold register is full.
- PAR  out  1  odd-parity bit for WORD, i.e. ~^WORD; registered together with WORD.
- OVRN  out  1  sticky overrun flag.
- ABRT  out  1  one-cycle pulse when a transfer is abandoned.
- BUSY  out  1  high while in state SHIFT.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; shift register, bit counter, timeout counter and PIOV edge register all cleared.
  - Outputs: WORD=0, PAR=1, WORD_VLD=0, OVRN=0, ABRT=0, BUSY=0.
  - The PIOV edge register resets to 0, so if PIOV is high when reset is released, a transfer starts on the first clock after release.
- States: IDLE, SHIFT.
- IDLE -> SHIFT: when PIOV=1 and the registered previous PIOV=0. On entry, bit counter=0 and timeout counter=0.
  - BIT_STB in the same cycle as the PIOV rising edge is ignored; the first bit is taken on a later strobe.
- SHIFT, BIT_STB=1:
  - shift register <= {shreg[WORD_BITS-2:0], DATAV}; bit counter += 1; timeout counter <= 0.
- SHIFT, BIT_STB=0:
  - timeout counter += 1.
  - When the timeout counter reaches TIMEOUT-1 with no strobe: ABRT pulses next cycle, the partial word is discarded, and the state returns to IDLE.
- Completion: a strobe while bit counter == WORD_BITS-1.
  - The completed word is {shreg[WORD_BITS-2:0], DATAV}; the state goes to IDLE.
  - If the hold register is empty, or WORD_VLD & ACC_RDY in that same cycle, the hold register loads the word and its parity; WORD_VLD=1 next cycle. Handshake and load in the same cycle give back-to-back operation with no bubble.
  - Otherwise the word is discarded, OVRN is set, and the hold register is unchanged.
- PIOV falling while in SHIFT, with no completion in that cycle: ABRT pulses, partial word discarded, state returns to IDLE.
- PIOV falling in the same cycle as the completing strobe: completion takes precedence; no ABRT.
- A new transfer requires a fresh PIOV rising edge. PIOV held high after completion does not restart a transfer.
- Handshake:
  - WORD_VLD & ACC_RDY clears WORD_VLD next cycle unless a load happens in the same cycle.
  - WORD and PAR do not change while WORD_VLD=1 except on that simultaneous load.
- OVRN:
  - Set by an overrun; cleared by CLR_OVRN.
  - Overrun and CLR_OVRN in the same cycle leave OVRN=1 (set wins).
- ABRT is a registered pulse of exactly one cycle; at most one ABRT per transfer.
- Timing: WORD_VLD rises one SIM_CLK cycle after the final strobe. A full transfer takes WORD_BITS strobes.
- Reset during SHIFT: the transfer is lost; no ABRT pulse and no OVRN.

Test Plan:
- PIOV rise, then 26 strobes serialising 0x2AAAAAA MSB-first, ACC_RDY=0 -> WORD=0x2AAAAAA, PAR=0 (13 ones), WORD_VLD=1 one cycle after the last strobe, BUSY low.
- Second full transfer of 0x0000001 while WORD_VLD=1 and ACC_RDY=0 -> OVRN=1, WORD remains 0x2AAAAAA. Then CLR_OVRN -> OVRN=0.
- Two transfers back to back, with ACC_RDY=1 in the completion cycle of the second -> WORD changes from the first word to the second with WORD_VLD held at 1 and no gap. Words 0x3FFFFFF and 0x0000000 give PAR 1 then 1.
- PIOV dropped after 10 strobes -> single-cycle ABRT, WORD_VLD unchanged. A new PIOV rise plus 26 strobes of 0x1234567 -> WORD=0x1234567.
- Strobes stop after 5 bits with PIOV held high -> ABRT exactly TIMEOUT cycles after the last strobe, BUSY=0, no new transfer until PIOV is toggled.
- SIM_RST asserted asynchronously mid-SHIFT with WORD_VLD=1 -> all outputs at reset values immediately, with no ABRT.
- PIOV falling in the same cycle as the 26th strobe -> WORD loaded, no ABRT.

Source files
------------

// File: rtl/lvda_data_receiver_if.sv
// ---------------------------------------------------------------------------
// lvda_data_receiver_if
// Signal bundle between the PIO side (LVDA serial input plus the consumer
// handshake) and the LVDA data receiver.
//   DATAV     serial data bit, valid when BIT_STB=1
//   PIOV      input-transfer enable; its rising edge starts a transfer
//   BIT_STB   one-cycle bit-time strobe
//   ACC_RDY   consumer ready
//   CLR_OVRN  synchronous clear of the overrun flag
//   WORD      assembled word (held while WORD_VLD=1)
//   WORD_VLD  hold register full
//   PAR       odd parity of WORD
//   OVRN      sticky overrun flag
//   ABRT      one-cycle abort pulse
//   BUSY      transfer in progress
// The master modport is the environment; the slave modport is the receiver.
// ---------------------------------------------------------------------------
interface lvda_data_receiver_if #(
  parameter int WORD_BITS = 26
);
  logic                 DATAV;
  logic                 PIOV;
  logic                 BIT_STB;
  logic                 ACC_RDY;
  logic                 CLR_OVRN;
  logic [WORD_BITS-1:0] WORD;
  logic                 WORD_VLD;
  logic                 PAR;
  logic                 OVRN;
  logic                 ABRT;
  logic                 BUSY;

  modport master (
    output DATAV, PIOV, BIT_STB, ACC_RDY, CLR_OVRN,
    input  WORD, WORD_VLD, PAR, OVRN, ABRT, BUSY
  );

  modport slave (
    input  DATAV, PIOV, BIT_STB, ACC_RDY, CLR_OVRN,
    output WORD, WORD_VLD, PAR, OVRN, ABRT, BUSY
  );
endinterface

// File: rtl/lvda_data_receiver.sv
// ---------------------------------------------------------------------------
// lvda_data_receiver
// Shifts in one LVDA serial word per PIO input transfer (MSB first, one bit
// per BIT_STB), then hands the word and its odd parity to the accumulator
// load logic through a one-entry hold register with a valid/ready handshake.
// Aborts on PIOV dropping mid-transfer or on a strobe stall, and flags
// overruns when a word completes while the hold register cannot take it.
// Ports:
//   SIM_CLK  system clock, rising edge
//   SIM_RST  asynchronous active-high reset
//   bus      lvda_data_receiver_if.slave (serial input, handshake, status)
// ---------------------------------------------------------------------------
module lvda_data_receiver #(
  parameter int WORD_BITS = 26,
  parameter int TIMEOUT   = 64,
  parameter int CW        = 7
) (
  input logic                 SIM_CLK,
  input logic                 SIM_RST,
  lvda_data_receiver_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [WORD_BITS-1:0] shreg_reg, shreg_next;
  logic [WORD_BITS-1:0] word_reg, word_next;
  logic [CW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [CW-1:0]        tmo_cnt_reg, tmo_cnt_next;
  logic                 piov_prev_reg;
  logic                 par_reg, par_next;
  logic                 vld_reg, vld_next;
  logic                 ovrn_reg, ovrn_next;
  logic                 abrt_reg, abrt_next;

  logic [WORD_BITS-1:0] shifted;
  logic                 take;
  logic                 last_stb;

  // Shift register contents after accepting the current DATAV bit; on the
  // final strobe this is the completed word.
  assign shifted  = {shreg_reg[WORD_BITS-2:0], bus.DATAV};
  assign take     = vld_reg & bus.ACC_RDY;
  assign last_stb = bus.BIT_STB && (bit_cnt_reg == LAST_BIT);

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      word_reg      <= '0;
      bit_cnt_reg   <= '0;
      tmo_cnt_reg   <= '0;
      piov_prev_reg <= 1'b0;
      par_reg       <= 1'b1;  // odd parity of an all-zero word
      vld_reg       <= 1'b0;
      ovrn_reg      <= 1'b0;
      abrt_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      word_reg      <= word_next;
      bit_cnt_reg   <= bit_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      piov_prev_reg <= bus.PIOV;
      par_reg       <= par_next;
      vld_reg       <= vld_next;
      ovrn_reg      <= ovrn_next;
      abrt_reg      <= abrt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    word_next    = word_reg;
    bit_cnt_next = bit_cnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    par_next     = par_reg;
    abrt_next    = 1'b0;
    // Consumer handshake empties the hold register unless a load below
    // refills it in the same cycle.
    vld_next     = vld_reg & ~take;
    ovrn_next    = ovrn_reg & ~bus.CLR_OVRN;

    unique case (state_reg)
      IDLE: begin
        // Strobes in the edge cycle are deliberately ignored.
        if (bus.PIOV && !piov_prev_reg) begin
          state_next   = SHIFT;
          shreg_next   = '0;
          bit_cnt_next = '0;
          tmo_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (last_stb) begin
          // Completion outranks a PIOV drop in the same cycle.
          state_next = IDLE;
          if (!vld_reg || take) begin
            word_next = shifted;
            par_next  = ~^shifted;
            vld_next  = 1'b1;
          end else begin
            ovrn_next = 1'b1;  // overrun wins over a simultaneous clear
          end
        end else if (!bus.PIOV || (!bus.BIT_STB && tmo_cnt_reg == TMO_LAST)) begin
          state_next = IDLE;
          abrt_next  = 1'b1;
        end else if (bus.BIT_STB) begin
          shreg_next   = shifted;
          bit_cnt_next = bit_cnt_reg + CW'(1);
          tmo_cnt_next = '0;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.WORD     = word_reg;
  assign bus.PAR      = par_reg;
  assign bus.WORD_VLD = vld_reg;
  assign bus.OVRN     = ovrn_reg;
  assign bus.ABRT     = abrt_reg;
  assign bus.BUSY     = (state_reg == SHIFT);

endmodule

// File: tb/tb_lvda_data_receiver.sv
// ---------------------------------------------------------------------------
// tb_lvda_data_receiver
// Drives PIO transfers into lvda_data_receiver. The driver keeps a
// transaction-level model of the hold register (occupancy, expected word
// queue, overrun flag, expected abort pulse); a monitor compares the DUT
// against it on every falling edge and pops the queue on each accepted word.
// ---------------------------------------------------------------------------
module tb_lvda_data_receiver;
  localparam int W   = 26;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvda_data_receiver_if #(.WORD_BITS(W)) ifc ();

  lvda_data_receiver #(.WORD_BITS(W), .TIMEOUT(TMO), .CW(7)) dut (
    .SIM_CLK (clk),
    .SIM_RST (rst),
    .bus     (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  bit           model_full = 0;
  bit           model_ovrn = 0;
  bit           model_abrt = 0;
  int           rdy_mode   = 0;  // 0 low, 1 high, 2 random

  function automatic bit odd_par(input logic [W-1:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One clock of stimulus; the model advances by the rules for the inputs
  // that the DUT sampled on this edge.
  task automatic tick(input logic piov, input logic stb, input logic d, input logic clr,
                      input bit complete, input logic [W-1:0] w, input bit abrt_exp);
    logic rdy;
    bit   take, ovr;
    rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    ifc.PIOV     = piov;
    ifc.BIT_STB  = stb;
    ifc.DATAV    = d;
    ifc.CLR_OVRN = clr;
    ifc.ACC_RDY  = rdy;
    @(posedge clk);
    if (!rst) begin
      take = model_full && rdy;
      ovr  = complete && model_full && !take;
      if (complete && !ovr) begin
        exp_q.push_back(w);
        model_full = 1;
      end else if (take) begin
        model_full = 0;
      end
      if (ovr) model_ovrn = 1;
      else if (clr) model_ovrn = 0;
      model_abrt = abrt_exp;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic clr);
    repeat (n) tick(1'b0, 1'b0, 1'b0, clr, 0, '0, 0);
  endtask

  // Full transfer: rise, WORD_BITS strobes with random gaps, then PIOV low.
  task automatic send_word(input logic [W-1:0] w, input int max_gap, input bit drop_last,
                           input int rdy_last, input logic clr_last);
    int saved;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 0);
    for (int i = 0; i < W; i++) begin
      repeat ($urandom_range(0, max_gap)) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 0);
      if (i == W - 1) begin
        saved    = rdy_mode;
        rdy_mode = rdy_last;
        tick(drop_last ? 1'b0 : 1'b1, 1'b1, w[W-1-i], clr_last, 1, w, 0);
        rdy_mode = saved;
      end else begin
        tick(1'b1, 1'b1, w[W-1-i], 1'b0, 0, '0, 0);
      end
    end
    idle(1, 1'b0);
  endtask

  // Partial transfer of nbits, then abandoned by PIOV drop (mode 0) or stall.
  task automatic abort_xfer(input logic [W-1:0] w, input int nbits, input int mode);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 0);
    for (int i = 0; i < nbits; i++) tick(1'b1, 1'b1, w[W-1-i], 1'b0, 0, '0, 0);
    if (mode == 0) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1);
    end else begin
      for (int k = 1; k <= TMO; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, k == TMO);
      chk("busy_after_timeout", ifc.BUSY, 0);
      repeat (5) tick(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 0);
      chk("no_restart_without_edge", ifc.BUSY, 0);
    end
    idle(1, 1'b0);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("word_vld", ifc.WORD_VLD, model_full);
        chk("ovrn", ifc.OVRN, model_ovrn);
        chk("abrt", ifc.ABRT, model_abrt);
        if (ifc.WORD_VLD) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%07h required=none at %0t", ifc.WORD, $time);
          end else begin
            chk("word", ifc.WORD, exp_q[0]);
            chk("par", ifc.PAR, odd_par(exp_q[0]));
            if (ifc.ACC_RDY) begin
              $display("[%0t] accept word=%07h par=%0b", $time, ifc.WORD, ifc.PAR);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w;
    int kind;
    ifc.PIOV = 0; ifc.BIT_STB = 0; ifc.DATAV = 0; ifc.ACC_RDY = 0; ifc.CLR_OVRN = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_word", ifc.WORD, 0);
    chk("rst_par", ifc.PAR, 1);
    chk("rst_vld", ifc.WORD_VLD, 0);
    chk("rst_busy", ifc.BUSY, 0);
    idle(2, 1'b0);

    // 1: alternating pattern, consumer not ready
    rdy_mode = 0;
    send_word(26'h2AAAAAA, 0, 0, 0, 1'b0);
    chk("t1_word", ifc.WORD, 26'h2AAAAAA);
    chk("t1_par", ifc.PAR, 0);
    chk("t1_busy", ifc.BUSY, 0);

    // 2: overrun with a simultaneous clear (set wins), then clear
    send_word(26'h0000001, 0, 0, 0, 1'b1);
    chk("t2_ovrn", ifc.OVRN, 1);
    chk("t2_word_kept", ifc.WORD, 26'h2AAAAAA);
    idle(1, 1'b1);
    chk("t2_ovrn_clr", ifc.OVRN, 0);

    // 3: drain, then back-to-back with handshake in the completion cycle
    rdy_mode = 1; idle(1, 1'b0); rdy_mode = 0;
    send_word(26'h3FFFFFF, 1, 0, 0, 1'b0);
    chk("t3_par1", ifc.PAR, 1);
    send_word(26'h0000000, 1, 0, 1, 1'b0);
    chk("t3_word2", ifc.WORD, 0);
    chk("t3_par2", ifc.PAR, 1);

    // 4: abort by PIOV drop, then a fresh transfer
    abort_xfer(26'h155AA33, 10, 0);
    chk("t4_vld_kept", ifc.WORD_VLD, 1);
    send_word(26'h1234567, 2, 0, 1, 1'b0);
    chk("t4_word", ifc.WORD, 26'h1234567);

    // 5: stall after 5 bits
    abort_xfer(26'h3C3C3C3, 5, 1);

    // 6: asynchronous reset mid-transfer with a word held
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 0);
    repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b0, 0, '0, 0);
    chk("t6_busy_before", ifc.BUSY, 1);
    #2;
    rst = 1;
    exp_q.delete(); model_full = 0; model_ovrn = 0; model_abrt = 0;
    #1;
    chk("t6_word", ifc.WORD, 0);
    chk("t6_par", ifc.PAR, 1);
    chk("t6_vld", ifc.WORD_VLD, 0);
    chk("t6_ovrn", ifc.OVRN, 0);
    chk("t6_abrt", ifc.ABRT, 0);
    chk("t6_busy", ifc.BUSY, 0);
    idle(2, 1'b0);
    rst = 0;
    idle(2, 1'b0);

    // 7: PIOV falls with the last strobe
    send_word(26'h2468ACE, 0, 1, 0, 1'b0);
    chk("t7_word", ifc.WORD, 26'h2468ACE);

    // Random traffic
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      w = W'($urandom);
      kind = $urandom_range(0, 11);
      if (kind < 9)       send_word(w, 4, kind == 0, 2, 1'($urandom_range(0, 3) == 0));
      else if (kind < 11) abort_xfer(w, $urandom_range(0, W - 1), 0);
      else                abort_xfer(w, $urandom_range(0, W - 1), 1);
      idle($urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    rdy_mode = 1;
    idle(3, 1'b0);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
